caf_foa_scheduler: RTL and testbench

Sequencer for a single shared frequency-shift + cross-correlation engine that sweeps all frequency-of-arrival (FOA) bins serially. On a start command it:

- fetches each bin's phase increment and shift direction from the FOA lookup memory;
- presents them to the shared `freq_shift` and starts one correlation pass per bin;
- tracks the peak magnitude across bins;
- emits one result word (bin, lag, peak) on an AXI-stream-style output.

It sits between the capture/reference buffer control and the downstream peak-report consumer.

---
 rtl/caf_foa_scheduler_pkg.sv | 19 +
 rtl/caf_peak_tracker.sv | 45 ++++
 rtl/caf_foa_scheduler.sv | 171 +++++++++++++++++
 tb/tb_caf_foa_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/caf_foa_scheduler_pkg.sv
// Shared types for the FOA sweep scheduler: FSM state encoding and small helpers.
package caf_foa_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LUT_RD  = 3'd1,
        ST_CONFIG  = 3'd2,
        ST_RUN     = 3'd3,
        ST_WAIT    = 3'd4,
        ST_COMPARE = 3'd5,
        ST_OUTPUT  = 3'd6
    } state_t;

    // Everything except IDLE counts as an active sweep.
    function automatic logic isBusy(input state_t s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/caf_peak_tracker.sv
// Running best-of-sweep tracker: keeps the largest peak seen and the bin/lag
// it came from. A strict greater-than compare means ties keep the earlier bin.
module caf_peak_tracker #(
    parameter int FOA_BITS   = 3,
    parameter int INDEX_BITS = 4,
    parameter int MAX_BITS   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_update,
    input  logic [FOA_BITS-1:0]   i_bin,
    input  logic [INDEX_BITS-1:0] i_lag,
    input  logic [MAX_BITS-1:0]   i_max,
    output logic [FOA_BITS-1:0]   o_bestBin,
    output logic [INDEX_BITS-1:0] o_bestLag,
    output logic [MAX_BITS-1:0]   o_bestMax
);

    logic [FOA_BITS-1:0]   r_bestBin;
    logic [INDEX_BITS-1:0] r_bestLag;
    logic [MAX_BITS-1:0]   r_bestMax;

    // Clear at sweep start, otherwise take a candidate only if it strictly beats the best.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bestBin <= '0;
            r_bestLag <= '0;
            r_bestMax <= '0;
        end else if (i_clear) begin
            r_bestBin <= '0;
            r_bestLag <= '0;
            r_bestMax <= '0;
        end else if (i_update && (i_max > r_bestMax)) begin
            r_bestBin <= i_bin;
            r_bestLag <= i_lag;
            r_bestMax <= i_max;
        end
    end

    assign o_bestBin = r_bestBin;
    assign o_bestLag = r_bestLag;
    assign o_bestMax = r_bestMax;

endmodule

// File: rtl/caf_foa_scheduler.sv
// Serial FOA sweep sequencer: for each bin it reads the LUT, configures the
// shared frequency shifter, runs one correlation pass under a watchdog, and
// finally emits the best {bin, lag, peak} as a single stream word.
module caf_foa_scheduler
    import caf_foa_scheduler_pkg::*;
#(
    parameter int FOA_LEN        = 8,
    parameter int FOA_BITS       = 3,
    parameter int PHASE_BITS     = 10,
    parameter int INDEX_BITS     = 4,
    parameter int MAX_BITS       = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 m_axis_tvalid,
    output logic                                 s_axis_tready,
    output logic [FOA_BITS-1:0]                  lut_addr,
    input  logic [PHASE_BITS-1:0]                lut_freq_step,
    input  logic                                 lut_neg_shift,
    output logic [PHASE_BITS-1:0]                freq_step,
    output logic                                 neg_shift,
    output logic                                 eng_start,
    input  logic                                 eng_done,
    input  logic [MAX_BITS-1:0]                  eng_max,
    input  logic [INDEX_BITS-1:0]                eng_index,
    output logic                                 s_axis_tvalid,
    output logic [FOA_BITS+INDEX_BITS+MAX_BITS-1:0] s_axis_tdata,
    input  logic                                 m_axis_tready,
    output logic                                 busy,
    output logic                                 timeout_err
);

    // The watchdog starts at 0 in the first WAIT cycle; leaving when it would
    // reach TIMEOUT_CYCLES-1 gives TIMEOUT_CYCLES-1 WAIT cycles per timed-out bin.
    localparam int                     WD_BITS  = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_BITS-1:0]     WD_LAST  = WD_BITS'(TIMEOUT_CYCLES - 2);
    localparam logic [FOA_BITS-1:0]    LAST_BIN = FOA_BITS'(FOA_LEN - 1);

    state_t                  r_state;
    logic [FOA_BITS-1:0]     r_bin;
    logic [WD_BITS-1:0]      r_wd;
    logic [MAX_BITS-1:0]     r_engMax;
    logic [INDEX_BITS-1:0]   r_engIndex;
    logic                    r_binValid;
    logic [FOA_BITS-1:0]     r_lutAddr;
    logic [PHASE_BITS-1:0]   r_freqStep;
    logic                    r_negShift;
    logic                    r_engStart;
    logic                    r_tready;
    logic                    r_tvalid;
    logic                    r_timeoutErr;

    logic                    w_accept;
    logic                    w_update;
    logic [FOA_BITS-1:0]     w_bestBin;
    logic [INDEX_BITS-1:0]   w_bestLag;
    logic [MAX_BITS-1:0]     w_bestMax;

    assign w_accept = (r_state == ST_IDLE) && r_tready && m_axis_tvalid;
    assign w_update = (r_state == ST_COMPARE) && r_binValid;

    caf_peak_tracker #(
        .FOA_BITS   (FOA_BITS),
        .INDEX_BITS (INDEX_BITS),
        .MAX_BITS   (MAX_BITS)
    ) u_tracker (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_accept),
        .i_update  (w_update),
        .i_bin     (r_bin),
        .i_lag     (r_engIndex),
        .i_max     (r_engMax),
        .o_bestBin (w_bestBin),
        .o_bestLag (w_bestLag),
        .o_bestMax (w_bestMax)
    );

    // Sweep FSM with registered handshake, LUT address, shifter config and watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bin        <= '0;
            r_wd         <= '0;
            r_engMax     <= '0;
            r_engIndex   <= '0;
            r_binValid   <= 1'b0;
            r_lutAddr    <= '0;
            r_freqStep   <= '0;
            r_negShift   <= 1'b0;
            r_engStart   <= 1'b0;
            r_tready     <= 1'b0;
            r_tvalid     <= 1'b0;
            r_timeoutErr <= 1'b0;
        end else begin
            r_engStart <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tready <= 1'b1;
                    if (w_accept) begin
                        r_tready     <= 1'b0;
                        r_bin        <= '0;
                        r_lutAddr    <= '0;
                        r_timeoutErr <= 1'b0;
                        r_wd         <= '0;
                        r_state      <= ST_LUT_RD;
                    end
                end
                ST_LUT_RD: begin
                    r_state <= ST_CONFIG;
                end
                ST_CONFIG: begin
                    r_freqStep <= lut_freq_step;
                    r_negShift <= lut_neg_shift;
                    r_engStart <= 1'b1;
                    r_state    <= ST_RUN;
                end
                ST_RUN: begin
                    r_wd    <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        r_engMax   <= eng_max;
                        r_engIndex <= eng_index;
                        r_binValid <= 1'b1;
                        r_state    <= ST_COMPARE;
                    end else if (r_wd == WD_LAST) begin
                        r_timeoutErr <= 1'b1;
                        r_binValid   <= 1'b0;
                        r_state      <= ST_COMPARE;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                ST_COMPARE: begin
                    if (r_bin == LAST_BIN) begin
                        r_tvalid <= 1'b1;
                        r_state  <= ST_OUTPUT;
                    end else begin
                        r_bin     <= r_bin + 1'b1;
                        r_lutAddr <= r_bin + 1'b1;
                        r_state   <= ST_LUT_RD;
                    end
                end
                ST_OUTPUT: begin
                    if (m_axis_tready) begin
                        r_tvalid <= 1'b0;
                        r_tready <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axis_tready = r_tready;
    assign lut_addr      = r_lutAddr;
    assign freq_step     = r_freqStep;
    assign neg_shift     = r_negShift;
    assign eng_start     = r_engStart;
    assign s_axis_tvalid = r_tvalid;
    assign s_axis_tdata  = r_tvalid ? {w_bestBin, w_bestLag, w_bestMax} : '0;
    assign busy          = isBusy(r_state);
    assign timeout_err   = r_timeoutErr;

endmodule

// File: tb/tb_caf_foa_scheduler.sv
// Directed bench for the FOA sweep scheduler: a LUT model, a correlation
// engine model with per-bin results, a table of sweep vectors, and hand
// sequences for backpressure, config stability and mid-sweep reset.
module tb_caf_foa_scheduler;

    localparam int FOA_LEN        = 8;
    localparam int FOA_BITS       = 3;
    localparam int PHASE_BITS     = 10;
    localparam int INDEX_BITS     = 4;
    localparam int MAX_BITS       = 32;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int K              = 5;
    localparam int DW             = FOA_BITS + INDEX_BITS + MAX_BITS;
    localparam int NVEC           = 7;

    logic                  clk;
    logic                  rst_n;
    logic                  m_axis_tvalid;
    logic                  s_axis_tready;
    logic [FOA_BITS-1:0]   lut_addr;
    logic [PHASE_BITS-1:0] lut_freq_step;
    logic                  lut_neg_shift;
    logic [PHASE_BITS-1:0] freq_step;
    logic                  neg_shift;
    logic                  eng_start;
    logic                  eng_done;
    logic [MAX_BITS-1:0]   eng_max;
    logic [INDEX_BITS-1:0] eng_index;
    logic                  s_axis_tvalid;
    logic [DW-1:0]         s_axis_tdata;
    logic                  m_axis_tready;
    logic                  busy;
    logic                  timeout_err;

    typedef struct {
        logic [7:0][31:0] maxv;
        logic [7:0][3:0]  idxv;
        logic [7:0]       noDone;
        logic [2:0]       expBin;
        logic [3:0]       expLag;
        logic [31:0]      expMax;
        logic             expErr;
    } vec_t;

    vec_t                  vecs [NVEC];
    logic [31:0]           engMaxTab [8];
    logic [3:0]            engIdxTab [8];
    logic [7:0]            noDoneMask;
    logic [PHASE_BITS-1:0] lutStep [8];
    logic                  lutNeg [8];
    logic [PHASE_BITS-1:0] cfgStepAtStart [8];
    logic [PHASE_BITS-1:0] cfgStepAtDone [8];
    logic                  cfgNegAtStart [8];
    logic                  cfgNegAtDone [8];
    int                    startCount;
    int                    engCnt;
    int                    total;
    int                    bad;

    caf_foa_scheduler #(
        .FOA_LEN        (FOA_LEN),
        .FOA_BITS       (FOA_BITS),
        .PHASE_BITS     (PHASE_BITS),
        .INDEX_BITS     (INDEX_BITS),
        .MAX_BITS       (MAX_BITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m_axis_tvalid (m_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .lut_addr      (lut_addr),
        .lut_freq_step (lut_freq_step),
        .lut_neg_shift (lut_neg_shift),
        .freq_step     (freq_step),
        .neg_shift     (neg_shift),
        .eng_start     (eng_start),
        .eng_done      (eng_done),
        .eng_max       (eng_max),
        .eng_index     (eng_index),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous LUT: data for an address appears one cycle later.
    always @(posedge clk) begin
        lut_freq_step <= lutStep[lut_addr];
        lut_neg_shift <= lutNeg[lut_addr];
    end

    // Engine model: done pulses K cycles after start unless the bin is set to hang.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            engCnt   <= 0;
            eng_done <= 1'b0;
        end else begin
            eng_done <= 1'b0;
            if (eng_start) begin
                if (!noDoneMask[lut_addr]) begin
                    if (K == 1) eng_done <= 1'b1;
                    else        engCnt   <= K - 1;
                end
            end else if (engCnt > 0) begin
                engCnt <= engCnt - 1;
                if (engCnt == 1) eng_done <= 1'b1;
            end
        end
    end

    assign eng_max   = engMaxTab[lut_addr];
    assign eng_index = engIdxTab[lut_addr];

    // One comparison: counts it, and reports a mismatch with both values.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
        end
    endtask

    // Load engine behaviour for vector v, issue a start, and wait for the result word.
    task automatic applyStimulus(input int v, output int latency);
        int guard;
        for (int b = 0; b < 8; b++) begin
            engMaxTab[b]      = vecs[v].maxv[b];
            engIdxTab[b]      = vecs[v].idxv[b];
            cfgStepAtStart[b] = '0;
            cfgStepAtDone[b]  = '0;
            cfgNegAtStart[b]  = 1'b0;
            cfgNegAtDone[b]   = 1'b0;
        end
        noDoneMask = vecs[v].noDone;
        startCount = 0;
        latency    = -1;
        guard      = 0;
        @(negedge clk);
        while (!s_axis_tready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!s_axis_tready) begin
            checkOutput($sformatf("v%0d_start_ready", v), 64'(s_axis_tready), 64'd1);
            return;
        end
        m_axis_tvalid = 1'b1;
        @(posedge clk);
        #1;
        m_axis_tvalid = 1'b0;
        checkOutput($sformatf("v%0d_busy_after_start", v), 64'(busy), 64'd1);
        checkOutput($sformatf("v%0d_err_cleared", v), 64'(timeout_err), 64'd0);
        latency = 0;
        while (!s_axis_tvalid && latency < 3000) begin
            @(posedge clk);
            #1;
            latency++;
            if (eng_start) begin
                startCount++;
                cfgStepAtStart[lut_addr] = freq_step;
                cfgNegAtStart[lut_addr]  = neg_shift;
            end
            if (eng_done) begin
                cfgStepAtDone[lut_addr] = freq_step;
                cfgNegAtDone[lut_addr]  = neg_shift;
            end
        end
        if (!s_axis_tvalid) latency = -1;
    endtask

    // Complete the output handshake and confirm the return to IDLE.
    task automatic finishResult(input string name);
        @(negedge clk);
        m_axis_tready = 1'b1;
        @(posedge clk);
        #1;
        m_axis_tready = 1'b0;
        checkOutput({name, "_tvalid_drop"}, 64'(s_axis_tvalid), 64'd0);
        checkOutput({name, "_idle"}, {62'd0, busy, s_axis_tready}, 64'd1);
    endtask

    initial begin
        int     lat;
        int     expLat;
        int     guard;
        logic   stableOk;
        logic   cfgOk;
        logic   sawTvalid;
        logic [DW-1:0] held;

        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        m_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        noDoneMask = '0;
        for (int b = 0; b < 8; b++) begin
            lutStep[b]   = PHASE_BITS'(b * 37 + 5);
            lutNeg[b]    = ((b % 2) == 1);
            engMaxTab[b] = '0;
            engIdxTab[b] = '0;
        end
        lutStep[4] = 10'h3FF;
        lutNeg[4]  = 1'b1;

        for (int b = 0; b < 8; b++) begin
            vecs[0].maxv[b] = 32'(10 * b);
            vecs[0].idxv[b] = 4'(b);
            vecs[1].maxv[b] = ((b == 2) || (b == 5)) ? 32'd500 : 32'd100;
            vecs[1].idxv[b] = 4'(b);
            vecs[2].maxv[b] = (b == 3) ? 32'd999 : 32'(10 * b);
            vecs[2].idxv[b] = 4'(b);
            vecs[3].maxv[b] = (b == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
            vecs[3].idxv[b] = 4'(15 - b);
            vecs[4].maxv[b] = 32'(1000 + b);
            vecs[4].idxv[b] = 4'(b);
            vecs[5].maxv[b] = 32'd0;
            vecs[5].idxv[b] = 4'(b + 8);
            vecs[6].maxv[b] = 32'd42;
            vecs[6].idxv[b] = 4'(15 - b);
        end
        vecs[0].noDone = 8'h00; vecs[0].expBin = 3'd7; vecs[0].expLag = 4'd7;  vecs[0].expMax = 32'd70;         vecs[0].expErr = 1'b0;
        vecs[1].noDone = 8'h00; vecs[1].expBin = 3'd2; vecs[1].expLag = 4'd2;  vecs[1].expMax = 32'd500;        vecs[1].expErr = 1'b0;
        vecs[2].noDone = 8'h08; vecs[2].expBin = 3'd7; vecs[2].expLag = 4'd7;  vecs[2].expMax = 32'd70;         vecs[2].expErr = 1'b1;
        vecs[3].noDone = 8'h00; vecs[3].expBin = 3'd0; vecs[3].expLag = 4'd15; vecs[3].expMax = 32'hFFFF_FFFF; vecs[3].expErr = 1'b0;
        vecs[4].noDone = 8'hFF; vecs[4].expBin = 3'd0; vecs[4].expLag = 4'd0;  vecs[4].expMax = 32'd0;          vecs[4].expErr = 1'b1;
        vecs[5].noDone = 8'h00; vecs[5].expBin = 3'd0; vecs[5].expLag = 4'd0;  vecs[5].expMax = 32'd0;          vecs[5].expErr = 1'b0;
        vecs[6].noDone = 8'h00; vecs[6].expBin = 3'd0; vecs[6].expLag = 4'd15; vecs[6].expMax = 32'd42;         vecs[6].expErr = 1'b0;

        // Power-on reset: every output low while reset is held.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_outputs", {6'd0, s_axis_tready, lut_addr, freq_step, neg_shift, eng_start,
                                      s_axis_tvalid, s_axis_tdata, busy, timeout_err}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_low_at_release", 64'(s_axis_tready), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("ready_after_release", {62'd0, busy, s_axis_tready}, 64'd1);

        // Table-driven sweeps.
        for (int v = 0; v < NVEC; v++) begin
            expLat = 0;
            for (int b = 0; b < 8; b++)
                expLat += vecs[v].noDone[b] ? (TIMEOUT_CYCLES + 3) : (K + 4);
            applyStimulus(v, lat);
            checkOutput($sformatf("v%0d_latency", v), 64'(lat), 64'(expLat));
            checkOutput($sformatf("v%0d_tvalid", v), 64'(s_axis_tvalid), 64'd1);
            checkOutput($sformatf("v%0d_tdata", v), 64'(s_axis_tdata),
                        64'({vecs[v].expBin, vecs[v].expLag, vecs[v].expMax}));
            checkOutput($sformatf("v%0d_timeout_err", v), 64'(timeout_err), 64'(vecs[v].expErr));
            if (v == 0) begin
                // Backpressure: result must hold for 20 cycles with tready low.
                held     = s_axis_tdata;
                stableOk = 1'b1;
                repeat (20) begin
                    @(posedge clk);
                    #1;
                    if (!s_axis_tvalid || (s_axis_tdata !== held)) stableOk = 1'b0;
                end
                checkOutput("bp_stable", 64'(stableOk), 64'd1);
                // Shifter configuration seen at each bin's start and done.
                checkOutput("start_pulses", 64'(startCount), 64'd8);
                checkOutput("bin4_step_start", 64'(cfgStepAtStart[4]), 64'h3FF);
                checkOutput("bin4_neg_start", 64'(cfgNegAtStart[4]), 64'd1);
                checkOutput("bin4_step_done", 64'(cfgStepAtDone[4]), 64'h3FF);
                checkOutput("bin4_neg_done", 64'(cfgNegAtDone[4]), 64'd1);
                cfgOk = 1'b1;
                for (int b = 0; b < 8; b++) begin
                    if ((cfgStepAtStart[b] !== lutStep[b]) || (cfgStepAtDone[b] !== lutStep[b]) ||
                        (cfgNegAtStart[b] !== lutNeg[b]) || (cfgNegAtDone[b] !== lutNeg[b]))
                        cfgOk = 1'b0;
                end
                checkOutput("all_bins_config", 64'(cfgOk), 64'd1);
            end
            finishResult($sformatf("v%0d", v));
        end

        // Reset during bin 3's WAIT abandons the sweep.
        for (int b = 0; b < 8; b++) begin
            engMaxTab[b] = vecs[0].maxv[b];
            engIdxTab[b] = vecs[0].idxv[b];
        end
        noDoneMask = '0;
        @(negedge clk);
        m_axis_tvalid = 1'b1;
        @(posedge clk);
        #1;
        m_axis_tvalid = 1'b0;
        guard = 0;
        while (!(eng_start && (lut_addr == 3'd3)) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("reach_bin3_start", 64'(eng_start && (lut_addr == 3'd3)), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midsweep_reset_outputs", {6'd0, s_axis_tready, lut_addr, freq_step, neg_shift, eng_start,
                                               s_axis_tvalid, s_axis_tdata, busy, timeout_err}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sawTvalid = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (s_axis_tvalid) sawTvalid = 1'b1;
        end
        checkOutput("no_result_after_abort", 64'(sawTvalid), 64'd0);
        checkOutput("idle_after_abort", {62'd0, busy, s_axis_tready}, 64'd1);
        applyStimulus(0, lat);
        checkOutput("post_reset_latency", 64'(lat), 64'd72);
        checkOutput("post_reset_tdata", 64'(s_axis_tdata), 64'({3'd7, 4'd7, 32'd70}));
        finishResult("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
